// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   rx_state_e        : receiver FSM states (idle, start bit, data bits, stop bit)
//   ClksPerBitDefault : clocks per bit period for 10 MHz / 115200 baud
//   DataBits/StopBits : 8N1 frame geometry
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    localparam int unsigned ClksPerBitDefault = 87;
    localparam int unsigned DataBits          = 8;
    localparam int unsigned StopBits          = 1;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer, start-edge detector, bit-timing FSM and
// LSB-first shift register.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx          : asynchronous serial line, idles high
//   byte_valid  : one-cycle pulse in the stop-sample cycle when the stop bit is high
//   byte_data   : received byte, valid alongside byte_valid
//   frame_err   : one-cycle pulse, the cycle after a low stop bit was sampled
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx,
    output logic                byte_valid,
    output logic [DataBits-1:0] byte_data,
    output logic                frame_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DataBits);

    // The counter starts at 0 in the cycle after the edge is seen (E+1), so a sample
    // "at count H from E" lands on cnt == H-1; likewise full bit periods end on C-1.
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DataBits - 1);

    logic                sync1_q, sync2_q, rx_prev_q;
    rx_state_e           state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic                frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntW'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        byte_valid  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Needs a high-to-low transition, so a line stuck low never retriggers.
                if (!sync2_q && rx_prev_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = sync2_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[DataBits-1:1]};
                    idx_d   = idx_q + IdxW'(1);
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (sync2_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign byte_data = shift_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/uart_rx_axis_fifo.sv
// UART receiver feeding a circular FIFO with an AXI-Stream master output.
//   clk, rst_n     : clock, asynchronous active-low reset
//   rx             : asynchronous 8N1 serial input
//   m_axis_tdata   : byte at the FIFO head
//   m_axis_tvalid  : FIFO not empty
//   m_axis_tready  : downstream accepts the current beat
//   frame_err      : one-cycle pulse on a low stop bit
//   overrun        : one-cycle pulse when a good byte is dropped on a full FIFO
//   fifo_count     : current occupancy
module uart_rx_axis_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [DataBits-1:0]           m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    logic                byte_valid;
    logic [DataBits-1:0] byte_data;

    logic [DataBits-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0]   count_q, count_d;
    logic                overrun_q;
    logic                full, pop, push;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign full = (count_q == CountW'(FIFO_DEPTH));
    assign pop  = m_axis_tvalid && m_axis_tready;
    // A full FIFO still accepts when the head leaves in the same cycle; the write then
    // lands in the slot being vacated, never in the new head.
    assign push = byte_valid && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CountW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CountW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= byte_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q   <= count_d;
            overrun_q <= byte_valid && !push;
        end
    end

    assign m_axis_tdata  = mem_q[rd_ptr_q];
    assign m_axis_tvalid = (count_q != '0);
    assign overrun       = overrun_q;
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Directed + randomized bench for uart_rx_axis_fifo. Expected bytes live in a queue;
// a negedge monitor pops it on every AXI beat and records pulse timing.
module tb_uart_rx_axis_fifo;

    localparam int unsigned C     = 87;
    localparam int unsigned H     = C / 2;
    localparam int unsigned Depth = 8;
    // Pin fall to first cycle where the frame's outcome is visible: 2 sync + H + 9 bits + 1.
    localparam int unsigned FrameLat = 2 + H + 9 * C + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       m_axis_tready = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       frame_err;
    logic       overrun;
    logic [3:0] fifo_count;

    uart_rx_axis_fifo #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (Depth)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int          beats = 0, fe_cnt = 0, ov_cnt = 0;
    int unsigned beat_cyc = 0, fe_cyc = 0, ov_cyc = 0, fall_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                beat_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("beat_while_none_expected", 32'(exp_q.size() != 0), 32'd1);
                end else begin
                    check("beat_tdata", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
            if (overrun) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
        end
    end

    // Ends at posedge+1 with the line back high; the stop bit lasts one full period.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1 rx = 1'b0;
        fall_cyc = cyc;
        repeat (C) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (C) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (C) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 m_axis_tready = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_tdata"}, 32'(m_axis_tdata), 32'h00);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int         b0, fe0, ov0, nbad;
    logic [7:0] d;
    logic       good;
    bit         done;

    initial begin
        // Reset
        tick(3);
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(C);
        check_reset_outputs("after_release");

        // Single byte, exact delivery cycle
        set_ready(1'b1);
        b0 = beats;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        tick(2);
        check("t1_beats", 32'(beats - b0), 32'd1);
        check("t1_latency", beat_cyc - fall_cyc, FrameLat);
        check("t1_frame_err", 32'(fe_cnt), 32'd0);
        check("t1_overrun", 32'(ov_cnt), 32'd0);

        // Backpressure fill, overrun, drain at full rate
        set_ready(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        tick(1);
        check("t2_count_full", 32'(fifo_count), 32'd8);
        check("t2_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t2_head_held", 32'(m_axis_tdata), 32'h00);
        ov0 = ov_cnt;
        send_byte(8'h08, 1'b1);
        tick(1);
        check("t2_overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
        check("t2_overrun_cycle", ov_cyc - fall_cyc, FrameLat);
        check("t2_count_after_ovr", 32'(fifo_count), 32'd8);
        check("t2_head_after_ovr", 32'(m_axis_tdata), 32'h00);
        set_ready(1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("t2_drained_count", 32'(fifo_count), 32'd0);
        check("t2_drained_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Framing error then recovery
        fe0 = fe_cnt;
        b0  = beats;
        send_byte(8'h3C, 1'b0);
        tick(C);
        check("t3_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("t3_fe_cycle", fe_cyc - fall_cyc, FrameLat);
        check("t3_no_beat", 32'(beats - b0), 32'd0);
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        tick(2);
        check("t3_recovered_beat", 32'(beats - b0), 32'd1);

        // Glitch shorter than half a bit
        fe0 = fe_cnt;
        b0  = beats;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx = 1'b1;
        tick(2 * C);
        check("t4_no_beat", 32'(beats - b0), 32'd0);
        check("t4_no_fe", 32'(fe_cnt - fe0), 32'd0);
        exp_q.push_back(8'h6E);
        send_byte(8'h6E, 1'b1);
        tick(2);
        check("t4_next_byte", 32'(beats - b0), 32'd1);

        // Full FIFO, pop coincides with the 9th byte's stop sample
        set_ready(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            send_byte(8'(8'h20 + i), 1'b1);
        end
        tick(1);
        check("t5_count_full", 32'(fifo_count), 32'd8);
        ov0 = ov_cnt;
        exp_q.push_back(8'h99);
        fork
            send_byte(8'h99, 1'b1);
            begin
                @(posedge clk);
                repeat (FrameLat - 1) @(posedge clk);
                #2 m_axis_tready = 1'b1;
                @(posedge clk);
                #2 m_axis_tready = 1'b0;
            end
        join
        tick(1);
        check("t5_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        check("t5_count_still_full", 32'(fifo_count), 32'd8);
        check("t5_new_head", 32'(m_axis_tdata), 32'h21);
        set_ready(1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("t5_drained_count", 32'(fifo_count), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 4 with a byte already buffered
        set_ready(1'b0);
        exp_q.push_back(8'h77);
        send_byte(8'h77, 1'b1);
        tick(1);
        check("t6_count_before", 32'(fifo_count), 32'd1);
        fork
            send_byte(8'hC3, 1'b1);
            begin
                @(posedge clk);
                repeat (5 * C + C / 2) @(posedge clk);
                #1 rst_n = 1'b0;
            end
        join
        exp_q.delete();
        tick(1);
        check_reset_outputs("t6_in_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(C);
        check_reset_outputs("t6_released");
        set_ready(1'b1);
        b0 = beats;
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        tick(2);
        check("t6_beat_after_reset", 32'(beats - b0), 32'd1);
        check("t6_latency", beat_cyc - fall_cyc, FrameLat);

        // Random bytes, random stop bits, random backpressure
        b0   = beats;
        fe0  = fe_cnt;
        ov0  = ov_cnt;
        nbad = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    d    = 8'($urandom);
                    good = ($urandom_range(0, 3) != 0);
                    if (good) exp_q.push_back(d);
                    else nbad++;
                    send_byte(d, good);
                    if (!good) repeat (C) @(posedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2 m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        set_ready(1'b1);
        tick(Depth + 2);
        check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rnd_beats", 32'(beats - b0), 32'(6 - nbad));
        check("rnd_frame_errs", 32'(fe_cnt - fe0), 32'(nbad));
        check("rnd_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        check("rnd_tvalid_low", 32'(m_axis_tvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis_fifo.md
# uart_rx_axis_fifo

Receive-side counterpart of the AXI-Stream-to-UART transmit path in `tt_um_top_axis_uart`. The block oversamples an asynchronous 8N1 serial line and reconstructs each byte. Accepted bytes are buffered in a small circular FIFO and presented on an AXI-Stream master port. It also reports framing errors and FIFO overruns as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per bit period (10 MHz / 115200 baud). Must be ≥ 8.
- `FIFO_DEPTH`, default 8: FIFO entries. Must be a power of two, ≥ 2.
- `clk` in, 1: single clock; all logic is rising-edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `rx` in, 1: serial line. Idles high. Asynchronous to `clk`.
- `m_axis_tdata` out, 8: byte at the FIFO head.
- `m_axis_tvalid` out, 1: FIFO not empty.
- `m_axis_tready` in, 1: downstream accepts the current beat.
- `frame_err` out, 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` out, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `fifo_count` out, $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, reset to 1. A third flop, `rx_prev`, is used for edge detection.
- **States:** IDLE, START, DATA, STOP.
- **IDLE:** wait for a falling edge (synced rx = 0 and `rx_prev` = 1), then go to START with the bit counter cleared. A line that is held low, such as after a framing error, never retriggers.
- **START:** at count H = CLKS_PER_BIT/2 (integer division), sample the line.
  - Low: go to DATA with the counter cleared and the bit index at 0.
  - High: treat as a glitch and return to IDLE.
- **DATA:** every CLKS_PER_BIT cycles, sample one bit, LSB first, into the shift register. After bit index 7 is sampled, go to STOP.
- **STOP:** after CLKS_PER_BIT cycles, sample the line, then go to IDLE in all cases.
  - High: push the byte into the FIFO.
  - Low: pulse `frame_err` and discard the byte.
- **FIFO push:** accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped and `overrun` pulses.
- **FIFO pop:** occurs when `m_axis_tvalid` and `m_axis_tready` are both high.
- **Simultaneous push and pop:** count is unchanged.
- **Pointers:** read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. `fifo_count` is tracked separately.
- **AXI-Stream output:** `m_axis_tdata` = mem[rd_ptr], `m_axis_tvalid` = (count != 0).
  - While tvalid is high and tready is low, tdata is held stable.
  - New pushes never alter the head entry.

## Timing
- **Reset values:** `m_axis_tvalid` 0, `m_axis_tdata` 8'h00 (storage cleared), `frame_err` 0, `overrun` 0, `fifo_count` 0, FSM in IDLE, synchronizer at 1.
- **Reset mid-frame:** the partial byte is abandoned and the FIFO is emptied. Nothing is delivered.
- **Reference cycle E:** the first cycle in which synced rx is low. E is 2 cycles after the pin falls.
- **Sampling points, relative to E:**
  - Start bit at E+H.
  - Data bit k (k = 0..7) at E+H+(k+1)·CLKS_PER_BIT.
  - Stop bit at E+H+9·CLKS_PER_BIT.
- **Output timing:**
  - The FIFO write is registered on the stop-sample edge.
  - `m_axis_tvalid` is high from E+H+9·CLKS_PER_BIT+1.
  - `frame_err` and `overrun` are high during that same cycle only.
- **Throughput:** one beat per cycle while tready is held high. Back-to-back frames need no idle bit beyond the stop bit, because the next start edge is detected from IDLE.

## Structure
- **Shared package `uart_pkg`:** RX state encoding (IDLE, START, DATA, STOP), the default CLKS_PER_BIT constant, and the 8N1 frame width constants (8 data bits, 1 stop bit).
- **Sub-module `uart_rx_core`:** synchronizer, FSM and shift register. It outputs a `byte_valid` pulse with `byte_data`, plus the `frame_err` pulse.
- **Top level:** the FIFO, overrun logic and AXI-Stream port are inline in `uart_rx_axis_fifo`.

## Test plan
1. **Single byte:** CLKS_PER_BIT=87, tready=1, send 0xA5. Expect exactly one beat with tdata 0xA5 at E+43+784. Expect frame_err=0 and overrun=0 throughout.
2. **Backpressure and overrun:**
   - Hold tready=0 and send 0x00..0x07. Expect `fifo_count`=8, tvalid high, tdata held at 0x00.
   - Send 0x08. Expect a one-cycle `overrun` pulse with count staying at 8.
   - Raise tready. Expect beats 0x00..0x07 in order, one per cycle, then tvalid=0.
3. **Framing error:**
   - Send 0x3C with the stop bit low. Expect a one-cycle `frame_err` pulse and no beat.
   - Return the line high for one bit period, then send 0x11. Expect 0x11 delivered.
4. **Glitch:** drive rx low for 20 cycles, then high. Expect no beat, no error, and the FSM back in IDLE.
5. **Full with simultaneous pop:** fill the FIFO to 8 entries, then assert tready for exactly the stop-sample cycle of a 9th byte 0x99. Expect no `overrun`, count stays 8, and 0x99 is the last beat drained.
6. **Reset mid-frame:** pull rst_n low during data bit 4 of a frame. Expect all outputs at their reset values. After release, send 0x5A and expect it delivered correctly.
